bcd_countdown_timer: RTL and testbench

Minutes:seconds countdown timer that holds a BCD preset and decrements it once per prescaled tick to 00:00, then raises an alarm. It is the down-counting counterpart of the project's up-counting clock/stopwatch datapath and sits between the front-panel button logic (load/start/pause pulses) and the 7-segment display driver. All state updates occur on the falling edge of `clk`, matching the rest of the codebase's sequential logic.

---
 rtl/timer_pkg.sv | 19 +
 rtl/bcd_digit_down.sv | 30 +++
 rtl/bcd_countdown_timer.sv | 131 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and BCD limits for the countdown timer
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX9 = 4'd9;
    localparam logic [3:0] BCD_MAX5 = 4'd5;

    // Saturate a preset digit to the largest legal value for its position
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one BCD down-counting digit with borrow out
module bcd_digit_down #(
    parameter logic [3:0] WRAP = 4'd9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] q,
    output logic       borrow
);

    logic [3:0] r_q;

    // Load wins over decrement; at zero the digit wraps to WRAP and borrows
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 4'd0;
        end else if (load) begin
            r_q <= load_val;
        end else if (dec) begin
            r_q <= (r_q == 4'd0) ? WRAP : (r_q - 4'd1);
        end
    end

    assign q      = r_q;
    assign borrow = dec & (r_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - MM:SS BCD countdown timer with prescaler and alarm
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic          r_running;
    logic          r_done;
    logic          r_alarm;

    logic [3:0] w_so, w_st, w_mo, w_mt;
    logic       w_b0, w_b1, w_b2, w_b3;
    logic [3:0] w_ld_so, w_ld_st, w_ld_mo, w_ld_mt;
    logic       w_wrap;
    logic       w_dec;
    logic       w_nonzero;
    logic       w_last;

    assign w_ld_so = clamp_digit(set_sec[3:0], BCD_MAX9);
    assign w_ld_st = clamp_digit(set_sec[7:4], BCD_MAX5);
    assign w_ld_mo = clamp_digit(set_min[3:0], BCD_MAX9);
    assign w_ld_mt = clamp_digit(set_min[7:4], BCD_MAX9);

    assign w_wrap    = (r_pre == PRE_MAX);
    // A coincident pause or load suppresses the tick's decrement
    assign w_dec     = (r_state == RUN) & ~load & ~pause & w_wrap;
    assign w_nonzero = |{w_mt, w_mo, w_st, w_so};
    // The decrement about to happen lands on 00:00
    assign w_last    = ({w_mt, w_mo, w_st, w_so} == 16'h0001);

    bcd_digit_down #(.WRAP(BCD_MAX9)) u_sec_ones (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(w_ld_so),
        .dec(w_dec), .q(w_so), .borrow(w_b0)
    );
    bcd_digit_down #(.WRAP(BCD_MAX5)) u_sec_tens (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(w_ld_st),
        .dec(w_b0), .q(w_st), .borrow(w_b1)
    );
    bcd_digit_down #(.WRAP(BCD_MAX9)) u_min_ones (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(w_ld_mo),
        .dec(w_b1), .q(w_mo), .borrow(w_b2)
    );
    // Minutes-tens borrow is never consumed: 00:00 leaves RUN before it could wrap
    bcd_digit_down #(.WRAP(BCD_MAX9)) u_min_tens (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(w_ld_mt),
        .dec(w_b2), .q(w_mt), .borrow(w_b3)
    );

    // Control FSM with prescaler and registered status outputs; load > pause > start
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pre     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_state   <= IDLE;
                r_pre     <= '0;
                r_running <= 1'b0;
                r_alarm   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!pause && start && w_nonzero) begin
                            r_state   <= RUN;
                            r_pre     <= '0;
                            r_running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            r_state   <= PAUSED;
                            r_running <= 1'b0;
                        end else if (w_wrap) begin
                            r_pre <= '0;
                            if (w_last) begin
                                r_state   <= EXPIRED;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                                r_alarm   <= 1'b1;
                            end
                        end else begin
                            r_pre <= r_pre + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (!pause && start) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    EXPIRED: begin
                        r_alarm <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign min     = {w_mt, w_mo};
    assign sec     = {w_st, w_so};
    assign running = r_running;
    assign done    = r_done;
    assign alarm   = r_alarm;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] set_min = 8'h00;
    logic [7:0] set_sec = 8'h00;
    logic [7:0] min;
    logic [7:0] sec;
    logic       running;
    logic       done;
    logic       alarm;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: total remaining seconds as a plain integer
    int m_total = 0;
    int m_mode  = 0;   // 0 idle, 1 run, 2 paused, 3 expired
    int m_pre   = 0;
    bit m_done  = 1'b0;

    bcd_countdown_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .start(start), .pause(pause),
        .set_min(set_min), .set_sec(set_sec), .min(min), .sec(sec),
        .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic int to_secs(input logic [7:0] mn, input logic [7:0] sc);
        int mt, mo, st, so;
        mt = int'(mn[7:4]); mo = int'(mn[3:0]);
        st = int'(sc[7:4]); so = int'(sc[3:0]);
        if (mt > 9) mt = 9;
        if (mo > 9) mo = 9;
        if (st > 5) st = 5;
        if (so > 9) so = 9;
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [7:0] m_min();
        return bcd2(m_total / 60);
    endfunction

    function automatic logic [7:0] m_sec();
        return bcd2(m_total % 60);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_total = 0; m_mode = 0; m_pre = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (load) begin
                m_total = to_secs(set_min, set_sec);
                m_mode = 0; m_pre = 0;
            end else if (m_mode == 0) begin
                if (!pause && start && m_total != 0) begin m_mode = 1; m_pre = 0; end
            end else if (m_mode == 1) begin
                if (pause) m_mode = 2;
                else if (m_pre == TD - 1) begin
                    m_pre = 0;
                    m_total = m_total - 1;
                    if (m_total == 0) begin m_mode = 3; m_done = 1'b1; end
                end else m_pre = m_pre + 1;
            end else if (m_mode == 2) begin
                if (!pause && start) m_mode = 1;
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n && cmp_en) begin
            chk("cmp_min", 32'(min), 32'(m_min()));
            chk("cmp_sec", 32'(sec), 32'(m_sec()));
            chk("cmp_running", 32'(running), 32'(m_mode == 1));
            chk("cmp_done", 32'(done), 32'(m_done));
            chk("cmp_alarm", 32'(alarm), 32'(m_mode == 3));
        end
    end

    task automatic step(input logic l, input logic s, input logic p,
                        input logic [7:0] mn, input logic [7:0] sc);
        @(posedge clk);
        load = l; start = s; pause = p; set_min = mn; set_sec = sc;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, set_min, set_sec);
    endtask

    // Pin both the DUT and the model to a hand-computed count
    task automatic expect_ms(input string name, input logic [7:0] mn, input logic [7:0] sc);
        chk({name, "_min"}, 32'(min), 32'(mn));
        chk({name, "_sec"}, 32'(sec), 32'(sc));
        chk({name, "_model"}, 32'({m_min(), m_sec()}), 32'({mn, sc}));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_min", 32'(min), 32'h00);
        chk("rst_sec", 32'(sec), 32'h00);
        chk("rst_flags", 32'({running, done, alarm}), 32'h0);
        @(posedge clk);
        reset_n = 1'b1;
        cmp_en = 1'b1;

        // 00:03 countdown to expiry
        step(1, 0, 0, 8'h00, 8'h03);
        step(0, 1, 0, 8'h00, 8'h03);
        expect_ms("cd3_s0", 8'h00, 8'h03);
        chk("cd3_running", 32'(running), 32'd1);
        idle(3);
        expect_ms("cd3_s3", 8'h00, 8'h03);
        idle(1);
        expect_ms("cd3_s4", 8'h00, 8'h02);
        idle(4);
        expect_ms("cd3_s8", 8'h00, 8'h01);
        chk("cd3_nodone", 32'(done), 32'd0);
        idle(4);
        expect_ms("cd3_s12", 8'h00, 8'h00);
        chk("cd3_done", 32'(done), 32'd1);
        chk("cd3_alarm", 32'(alarm), 32'd1);
        chk("cd3_stop", 32'(running), 32'd0);
        idle(1);
        chk("cd3_done_pulse", 32'(done), 32'd0);
        chk("cd3_alarm_hold", 32'(alarm), 32'd1);
        step(0, 1, 1, 8'h00, 8'h03);
        idle(5);
        chk("cd3_exp_ignore", 32'({running, alarm}), 32'b01);

        // 01:00 borrows into minutes
        step(1, 0, 0, 8'h01, 8'h00);
        chk("ld_clears_alarm", 32'(alarm), 32'd0);
        step(0, 1, 0, 8'h01, 8'h00);
        idle(4);
        expect_ms("borrow", 8'h00, 8'h59);

        // pause freezes count and prescaler; resume keeps prescaler phase
        step(1, 0, 0, 8'h00, 8'h05);
        step(0, 1, 0, 8'h00, 8'h05);
        idle(6);
        step(0, 0, 1, 8'h00, 8'h05);
        expect_ms("pause_f0", 8'h00, 8'h04);
        chk("pause_run", 32'(running), 32'd0);
        idle(20);
        expect_ms("pause_f20", 8'h00, 8'h04);
        step(0, 1, 0, 8'h00, 8'h05);
        idle(1);
        expect_ms("resume_1", 8'h00, 8'h04);
        idle(1);
        expect_ms("resume_2", 8'h00, 8'h03);

        // load sanitising
        step(1, 0, 0, 8'hA1, 8'h7C);
        expect_ms("clamp", 8'h91, 8'h59);

        // start at 00:00 ignored
        step(1, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'h00, 8'h00);
        chk("zero_start", 32'(running), 32'd0);

        // load + start together while running
        step(1, 0, 0, 8'h00, 8'h09);
        step(0, 1, 0, 8'h00, 8'h09);
        idle(2);
        step(1, 1, 0, 8'h00, 8'h07);
        expect_ms("ld_start", 8'h00, 8'h07);
        chk("ld_start_run", 32'(running), 32'd0);

        // pause on the wrap edge suppresses the decrement
        step(1, 0, 0, 8'h00, 8'h05);
        step(0, 1, 0, 8'h00, 8'h05);
        idle(3);
        step(0, 0, 1, 8'h00, 8'h05);
        expect_ms("pause_wrap", 8'h00, 8'h05);
        chk("pause_wrap_run", 32'(running), 32'd0);

        // asynchronous reset mid-count
        step(1, 0, 0, 8'h00, 8'h09);
        step(0, 1, 0, 8'h00, 8'h09);
        idle(5);
        @(posedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_min", 32'(min), 32'h00);
        chk("arst_sec", 32'(sec), 32'h00);
        chk("arst_flags", 32'({running, done, alarm}), 32'h0);
        @(posedge clk);
        reset_n = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic l, s, p;
            logic [7:0] mn, sc;
            l = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 19) == 0);
            mn = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            sc = 8'($urandom);
            step(l, s, p, mn, sc);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
